ex_div_iter: RTL
================

// Module: ex_div_iter
// PURPOSE
//  Parametrised iterative radix-2 divider for the EX stage. Executes div.w/mod.w/div.wu/mod.wu.
//  Uses valid/ready handshakes on input and output, a pass-through tag, and a cancel input for
//  exception/ertn flush. EX holds ready_go low until out_valid. Divide-by-zero and signed
//  overflow complete early.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  TAG_W   5   width of sideband tag carried with the op (e.g. rf_waddr)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      divider can accept (state IDLE)
//  div_op     in   4      one-hot: [0]div.w [1]mod.w [2]div.wu [3]mod.wu
//  div_src1   in   WIDTH  dividend
//  div_src2   in   WIDTH  divisor
//  in_tag     in   TAG_W  sideband, returned unchanged on out_tag
//  cancel     in   1      flush: abort any op in flight, drop pending result
//  out_valid  out  1      result valid (state DONE)
//  out_ready  in   1      consumer takes result
//  div_res    out  WIDTH  quotient or remainder per captured div_op
//  out_tag    out  TAG_W  tag captured at accept
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, busy=0, div_res=0, out_tag=0, counter=0; in_ready=1.
//  Accept: in_valid & in_ready & |div_op & ~cancel, sampled at the clock edge.
//   - in_valid with div_op==0 is ignored.
//   - Multi-hot div_op: the lowest set bit wins.
//   - Operands, op, tag and the result sign are registered on accept.
//  FSM (IDLE -> CALC -> DONE -> IDLE):
//   IDLE: in_ready=1. Accept -> CALC, cnt=0, rem=0, quo=|dividend| (|x| only for signed ops).
//    Divisor==0 or (signed & src1==MIN & src2==-1) -> DONE directly; result set on that edge.
//   CALC: each cycle shift {rem,quo} left 1; trial = rem_shifted - |divisor| (WIDTH+1 bits).
//    Non-negative trial: rem=trial, quo LSB=1. Otherwise quo LSB=0. cnt++.
//    When cnt==WIDTH-1 -> DONE. On that edge, register the sign-corrected result in div_res.
//   DONE: out_valid=1, div_res/out_tag stable. out_ready -> IDLE. No new accept in the same cycle.
//  Latency: accept at edge E. Normal op: out_valid first high in cycle E+WIDTH+1
//   (33 cycles for WIDTH=32). Special case: out_valid high at E+1.
//  Sign rules (signed ops): quotient negative iff src1 and src2 signs differ.
//   Remainder takes the sign of the dividend. Zero results are never negative.
//  Special results (no trap):
//   - x/0: quotient = all ones, remainder = x.
//   - MIN/-1: quotient = MIN, remainder = 0.
//  Unsigned ops: no sign correction. Operands are treated as WIDTH-bit unsigned.
//  cancel: highest priority. From any state -> IDLE on the next edge.
//   out_valid drops the next cycle. div_res/out_tag keep their last values.
//   cancel on the accept cycle blocks the accept. cancel in DONE with out_ready still discards.
//  Backpressure: DONE holds indefinitely while out_ready=0. Outputs are held bit-stable.
//  in_ready is 0 in CALC and DONE. Upstream must hold its request until in_ready.
//  Reset mid-operation: behaves as cancel plus reset values.
// TESTING
//  1 div.w 7/2, tag=5'h3, out_ready=1 -> out_valid at E+33, div_res=3, out_tag=3; mod.w -> 1.
//  2 div.w -7/2 -> 0xFFFFFFFD; mod.w -> 0xFFFFFFFF; div.wu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//  3 div.w 0x80000000/0xFFFFFFFF -> 0x80000000 at E+1; mod.w -> 0.
//    div.wu 0x1234/0 -> 0xFFFFFFFF at E+1; mod.wu -> 0x1234.
//  4 Start 100/7 with cancel at E+10 -> IDLE at E+11, out_valid never rises.
//    A new 9/3 request accepted at E+11 -> div_res=3.
//  5 out_ready=0 for 5 cycles after out_valid -> out_valid, div_res, out_tag unchanged,
//    in_ready=0. Raise out_ready -> in_ready=1 next cycle.
//  6 Back-to-back random signed/unsigned ops incl. div_op==0 and multi-hot, with in_valid
//    held -> every result matches a reference model; multi-hot uses the lowest bit;
//    div_op==0 never accepted.

Source files
------------

// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider for the EX stage (div.w / mod.w / div.wu / mod.wu).
// One quotient bit per cycle. Divide-by-zero and signed overflow finish on the accept edge.
// Valid/ready on both sides, a pass-through tag, and a cancel input for pipeline flushes.
module ex_div_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       div_op,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             mod_q, quo_neg_q, rem_neg_q;
  logic [WIDTH-1:0] div_res_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             op_signed, op_mod;
  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] abs1, abs2;
  logic             div_zero, ovf, special, accept, last;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, res_fix;

  // Decode the op with lowest-set-bit priority and prepare operands for accept
  always_comb begin
    op_signed = div_op[0] | div_op[1];
    if (div_op[0])      op_mod = 1'b0;
    else if (div_op[1]) op_mod = 1'b1;
    else if (div_op[2]) op_mod = 1'b0;
    else                op_mod = div_op[3];
    src1_neg = op_signed & div_src1[WIDTH-1];
    src2_neg = op_signed & div_src2[WIDTH-1];
    abs1     = src1_neg ? (WIDTH'(0) - div_src1) : div_src1;
    abs2     = src2_neg ? (WIDTH'(0) - div_src2) : div_src2;
    div_zero = (div_src2 == '0);
    ovf      = op_signed & (div_src1 == MinVal) & (div_src2 == '1);
    special  = div_zero | ovf;
    // x/0 -> all ones, remainder x; MIN/-1 -> MIN, remainder 0
    if (div_zero) special_res = op_mod ? div_src1 : '1;
    else          special_res = op_mod ? '0 : MinVal;
    accept   = in_valid & in_ready & (|div_op) & ~cancel;
  end

  // One restoring-division step plus sign correction of the final result
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    rem_nxt   = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_fix   = quo_neg_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
    rem_fix   = rem_neg_q ? (WIDTH'(0) - rem_nxt) : rem_nxt;
    res_fix   = mod_q ? rem_fix : quo_fix;
    last      = (cnt_q == CntW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; cancel overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (cancel) state_d = StIdle;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath: capture on accept, iterate in CALC, publish result on the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      mod_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div_res_q <= '0;
      out_tag_q <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= abs1;
      dvs_q     <= abs2;
      mod_q     <= op_mod;
      quo_neg_q <= src1_neg ^ src2_neg;
      rem_neg_q <= src1_neg;
      out_tag_q <= in_tag;
      if (special) div_res_q <= special_res;
    end else if (state_q == StCalc && !cancel) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + CntW'(1);
      if (last) div_res_q <= res_fix;
    end
  end

  assign div_res = div_res_q;
  assign out_tag = out_tag_q;

endmodule
